// File: rtl/cpu32_mc_if.sv
// Instruction and data bus bundle for cpu32_mc, with req/ready handshakes.
// Memories may hold ready low to insert wait states.
interface cpu32_mc_if;
  logic [31:0] i_addr;
  logic        i_req;
  logic [31:0] i_data;
  logic        i_ready;
  logic [31:0] d_addr;
  logic [31:0] d_data_w;
  logic [31:0] d_data_r;
  logic        d_req;
  logic        d_we;
  logic        d_ready;

  modport master (
    output i_addr, i_req, d_addr, d_data_w, d_req, d_we,
    input  i_data, i_ready, d_data_r, d_ready
  );

  modport slave (
    input  i_addr, i_req, d_addr, d_data_w, d_req, d_we,
    output i_data, i_ready, d_data_r, d_ready
  );
endinterface

// File: rtl/cpu32_mc.sv
// Multi-cycle 32-bit core: FETCH -> EXEC -> (MEM) with handshaked buses,
// illegal-opcode halt and a one-cycle retire strobe.
module cpu32_mc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit          R0_ZERO      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  cpu32_mc_if.master        bus,
  output logic              retire,
  output logic              halted
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] d_addr_q, d_addr_d;
  logic [XLEN-1:0] d_wdata_q, d_wdata_d;
  logic            d_we_q, d_we_d;
  logic            halted_d, retire_d;

  logic [XLEN-1:0] rf [NREG];
  logic            wr_en;
  logic [3:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  logic [3:0]      opcode, fn, ra, rb, rd;
  logic [15:0]     imm;
  logic [XLEN-1:0] rd_a, rd_b, pc_inc, br_off;
  logic            br_legal, br_take;

  assign opcode = ir_q[31:28];
  assign fn     = ir_q[27:24];
  assign ra     = ir_q[23:20];
  assign rb     = ir_q[19:16];
  assign rd     = ir_q[15:12];
  assign imm    = ir_q[15:0];

  // R0 reads as zero when hardwired; its storage is never written in that mode
  assign rd_a = (R0_ZERO && ra == 4'd0) ? '0 : rf[ra];
  assign rd_b = (R0_ZERO && rb == 4'd0) ? '0 : rf[rb];

  assign pc_inc   = pc_q + 32'd4;
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};
  assign br_legal = (fn <= 4'd2);
  assign br_take  = (fn == 4'd0) || (fn == 4'd1 && rd_a == '0) ||
                    (fn == 4'd2 && rd_a != '0);

  function automatic logic [XLEN-1:0] alu(input logic [3:0] f,
                                          input logic [XLEN-1:0] l,
                                          input logic [XLEN-1:0] r);
    case (f)
      4'd0:    alu = r;
      4'd1:    alu = l & r;
      4'd2:    alu = l | r;
      4'd3:    alu = l ^ r;
      4'd4:    alu = l + r;
      4'd5:    alu = l - r;
      4'd6:    alu = {31'd0, $signed(l) < $signed(r)};
      4'd7:    alu = {31'd0, l < r};
      4'd8:    alu = l << r[4:0];
      4'd9:    alu = l >> r[4:0];
      default: alu = '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      ir_q      <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_we_q    <= 1'b0;
      halted    <= 1'b0;
      retire    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_we_q    <= d_we_d;
      halted    <= halted_d;
      retire    <= retire_d;
    end
  end

  // Register file is deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en && !(R0_ZERO && wr_addr == 4'd0)) rf[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_we_d    = d_we_q;
    halted_d  = halted;
    retire_d  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = rb;
    wr_data   = '0;
    case (state_q)
      S_FETCH: begin
        if (bus.i_ready) begin
          ir_d    = bus.i_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          4'h0, 4'h1: begin
            wr_en    = 1'b1;
            wr_addr  = (opcode == 4'h0) ? rd : rb;
            wr_data  = alu(fn, rd_a, (opcode == 4'h0) ? rd_b : {16'h0, imm});
            pc_d     = pc_inc;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          4'h2, 4'h3: begin
            d_addr_d  = rd_a + {16'h0, imm};
            d_wdata_d = rd_b;
            d_we_d    = opcode[0];
            state_d   = S_MEM;
          end
          4'h4: begin
            if (br_legal) begin
              pc_d     = br_take ? (pc_q + br_off) : pc_inc;
              retire_d = 1'b1;
              state_d  = S_FETCH;
            end else begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
          end
          4'h5: begin
            // Jump target uses the pre-write R[b] even when d == b
            wr_en    = 1'b1;
            wr_addr  = rd;
            wr_data  = pc_inc;
            pc_d     = rd_b;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          default: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (bus.d_ready) begin
          wr_en    = !d_we_q;
          wr_data  = bus.d_data_r;
          pc_d     = pc_inc;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // Requests drop combinationally with reset so an in-flight access aborts at once
  assign bus.i_addr   = pc_q;
  assign bus.i_req    = (state_q == S_FETCH) && !reset;
  assign bus.d_req    = (state_q == S_MEM) && !reset;
  assign bus.d_addr   = d_addr_q;
  assign bus.d_data_w = d_wdata_q;
  assign bus.d_we     = d_we_q;

endmodule

// File: tb/tb_cpu32_mc.sv
// Directed-program bench for cpu32_mc: small programs run from fake memories,
// results checked against hand-computed values.
module tb_cpu32_mc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic retire, halted;
  logic i_rdy = 1'b1;
  int   d_wait = 0;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];

  int n_vec = 0, n_err = 0;
  int cyc = 0, nret = 0;
  int rt [64];

  always #5 clk = ~clk;

  cpu32_mc_if bif ();

  cpu32_mc #(.RESET_VECTOR(32'h100), .R0_ZERO(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bif.master),
    .retire (retire),
    .halted (halted)
  );

  assign bif.i_data  = imem[bif.i_addr[9:2]];
  assign bif.i_ready = i_rdy;

  // Retire timestamps, sampled at the edge (pre-update values)
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (retire === 1'b1 && nret < 64) begin
        rt[nret] = cyc;
        nret++;
      end
    end
  end

  // Data memory with d_wait wait states per access
  initial begin
    int cnt = 0;
    bif.d_ready  = 1'b0;
    bif.d_data_r = '0;
    forever begin
      @(negedge clk);
      if (bif.d_req) begin
        if (cnt < d_wait) begin
          cnt++;
          bif.d_ready = 1'b0;
        end else begin
          cnt = 0;
          bif.d_ready = 1'b1;
          if (bif.d_we) dmem[bif.d_addr[7:2]] = bif.d_data_w;
          bif.d_data_r = dmem[bif.d_addr[7:2]];
        end
      end else begin
        cnt = 0;
        bif.d_ready = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] fn,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [15:0] imm);
    return {op, fn, ra, rb, imm};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    imem[addr[9:2]] = word;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
  endtask

  task automatic start();
    reset = 1'b1;
    i_rdy = 1'b1;
    repeat (2) @(negedge clk);
    nret  = 0;
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic wait_dreq(input int budget);
    int k = 0;
    while (!bif.d_req && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("dreq_seen", 32'(bif.d_req), 32'd1);
  endtask

  task automatic branch_run(input string tag, input logic [3:0] fn, input logic [15:0] imm,
                            input logic [31:0] exp_pc, input int exp_nret);
    clear_mem();
    put(32'h100, ins(4'h1, 4'h0, 4'h0, 4'd13, 16'h0020));
    put(32'h104, ins(4'h5, 4'h0, 4'h0, 4'd13, 16'hE000));
    put(32'h020, ins(4'h4, fn, 4'h0, 4'h0, imm));
    start();
    wait_halt(100);
    check({tag, "_pc"}, bif.i_addr, exp_pc);
    check({tag, "_nret"}, 32'(nret), 32'(exp_nret));
  endtask

  initial begin
    logic [31:0] a0, w0;
    logic        we0;
    int          cnt, bad;

    // ALU program, zero wait states
    clear_mem();
    put(32'h100, ins(4'h1, 4'h4, 4'd0, 4'd1, 16'h7FFF));
    put(32'h104, ins(4'h0, 4'h5, 4'd0, 4'd1, 16'h2000));
    put(32'h108, ins(4'h1, 4'h0, 4'd0, 4'd5, 16'h0001));
    put(32'h10C, ins(4'h1, 4'h8, 4'd5, 4'd6, 16'd31));
    put(32'h110, ins(4'h0, 4'h6, 4'd6, 4'd5, 16'h7000));
    put(32'h114, ins(4'h0, 4'h7, 4'd6, 4'd5, 16'h8000));
    put(32'h118, ins(4'h1, 4'h3, 4'd2, 4'd9, 16'hFFFF));
    put(32'h11C, ins(4'h1, 4'h0, 4'd0, 4'd10, 16'h0007));
    put(32'h120, ins(4'h1, 4'hC, 4'd2, 4'd10, 16'h0005));
    put(32'h124, ins(4'h1, 4'h4, 4'd0, 4'd0, 16'h0005));
    put(32'h128, ins(4'h1, 4'h4, 4'd0, 4'd11, 16'h0003));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ireq", 32'(bif.i_req), 32'd0);
    nret  = 0;
    reset = 1'b0;
    #1;
    check("rst_iaddr", bif.i_addr, 32'h100);
    check("rst_ireq_after", 32'(bif.i_req), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_dreq", 32'(bif.d_req), 32'd0);
    wait_halt(200);
    check("add_imm", dut.rf[1], 32'h0000_7FFF);
    check("sub_reg", dut.rf[2], 32'hFFFF_8001);
    check("shl_31", dut.rf[6], 32'h8000_0000);
    check("slt", dut.rf[7], 32'd1);
    check("sltu", dut.rf[8], 32'd0);
    check("xor_imm", dut.rf[9], 32'hFFFF_7FFE);
    check("func12_zero", dut.rf[10], 32'd0);
    check("r0_hardwired", dut.rf[11], 32'd3);
    check("alu_nret", 32'(nret), 32'd11);
    check("alu_cpi", 32'(rt[1] - rt[0]), 32'd2);
    check("alu_span", 32'(rt[10] - rt[0]), 32'd20);
    check("halt_pc", bif.i_addr, 32'h12C);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bif.i_req || bif.d_req || retire) bad++;
    end
    check("halt_idle", 32'(bad), 32'd0);
    check("halt_nret", 32'(nret), 32'd11);

    // Store then load with 3 wait states
    clear_mem();
    put(32'h100, ins(4'h1, 4'h0, 4'd0, 4'd3, 16'hDEAD));
    put(32'h104, ins(4'h1, 4'h8, 4'd3, 4'd3, 16'd16));
    put(32'h108, ins(4'h1, 4'h2, 4'd3, 4'd3, 16'hBEEF));
    put(32'h10C, ins(4'h1, 4'h0, 4'd0, 4'd12, 16'h0020));
    put(32'h110, ins(4'h3, 4'h0, 4'd12, 4'd3, 16'h0010));
    put(32'h114, ins(4'h2, 4'h0, 4'd12, 4'd4, 16'h0010));
    d_wait = 3;
    start();
    wait_dreq(40);
    a0 = bif.d_addr; w0 = bif.d_data_w; we0 = bif.d_we;
    cnt = 0; bad = 0;
    while (bif.d_req && cnt < 50) begin
      cnt++;
      if (bif.d_addr !== a0 || bif.d_data_w !== w0 || bif.d_we !== we0) bad++;
      @(negedge clk);
    end
    check("sw_dreq_cycles", 32'(cnt), 32'd4);
    check("sw_addr", a0, 32'h30);
    check("sw_data", w0, 32'hDEAD_BEEF);
    check("sw_we", 32'(we0), 32'd1);
    check("sw_stable", 32'(bad), 32'd0);
    wait_dreq(40);
    check("lw_we", 32'(bif.d_we), 32'd0);
    wait_halt(100);
    check("sw_mem", dmem[12], 32'hDEAD_BEEF);
    check("lw_reg", dut.rf[4], 32'hDEAD_BEEF);
    check("mem_nret", 32'(nret), 32'd6);
    check("sw_cycles", 32'(rt[4] - rt[3]), 32'd6);
    check("lw_cycles", 32'(rt[5] - rt[4]), 32'd6);
    d_wait = 0;

    // Branches at pc=0x20, reached by jump-and-link
    branch_run("br_eqz_taken", 4'h1, 16'hFFFF, 32'h1C, 3);
    check("jal_link_108", dut.rf[14], 32'h108);
    branch_run("br_nez_not", 4'h2, 16'hFFFF, 32'h24, 3);
    branch_run("br_always_fwd", 4'h0, 16'h0010, 32'h60, 3);
    branch_run("br_illegal", 4'h3, 16'h0000, 32'h20, 2);

    // Jump-and-link, including d == b
    clear_mem();
    put(32'h100, ins(4'h1, 4'h0, 4'd0, 4'd1, 16'h0200));
    put(32'h104, ins(4'h1, 4'h0, 4'd0, 4'd13, 16'h0040));
    put(32'h108, ins(4'h5, 4'h0, 4'd0, 4'd13, 16'hE000));
    put(32'h040, ins(4'h5, 4'h0, 4'd0, 4'd1, 16'hF000));
    put(32'h200, ins(4'h1, 4'h0, 4'd0, 4'd2, 16'h0300));
    put(32'h204, ins(4'h5, 4'h0, 4'd0, 4'd2, 16'h2000));
    start();
    wait_halt(100);
    check("jal_link", dut.rf[15], 32'h44);
    check("jal_same_reg", dut.rf[2], 32'h208);
    check("jal_target", bif.i_addr, 32'h300);
    check("jal_nret", 32'(nret), 32'd6);

    // Reset during a stalled load, then fetch wait states
    clear_mem();
    dmem[12] = 32'hCAFE_F00D;
    put(32'h100, ins(4'h1, 4'h0, 4'd0, 4'd4, 16'h1234));
    put(32'h104, ins(4'h2, 4'h0, 4'd0, 4'd4, 16'h0030));
    d_wait = 50;
    start();
    wait_dreq(40);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_dreq", 32'(bif.d_req), 32'd0);
    check("rst_mid_ireq", 32'(bif.i_req), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_mid_reg", dut.rf[4], 32'h1234);
    check("rst_mid_halted", 32'(halted), 32'd0);
    i_rdy = 1'b0;
    nret  = 0;
    reset = 1'b0;
    #1;
    check("refetch_addr", bif.i_addr, 32'h100);
    repeat (3) @(negedge clk);
    check("fetch_wait_ireq", 32'(bif.i_req), 32'd1);
    check("fetch_wait_addr", bif.i_addr, 32'h100);
    check("fetch_wait_nret", 32'(nret), 32'd0);
    d_wait = 0;
    i_rdy  = 1'b1;
    wait_halt(100);
    check("lw_after_reset", dut.rf[4], 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu32_mc.md
Name: cpu32_mc

Overview:
- Multi-cycle successor to the single-cycle cpu32 core.
- Same 32-bit instruction format and 16-entry register file, decoded as opcode[31:28], func[27:24], a[23:20], b[19:16], d[15:12], imm16[15:0].
- Adds req/ready handshakes on the instruction and data buses so memories may insert wait states.
- Adds a parametrised reset vector, optional hardwired R0, illegal-opcode halt, and a retire strobe for the bench.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- R0_ZERO, 1, 1 = R0 always reads 0 and ignores writes; 0 = R0 is a normal register.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_addr  out  32  instruction address; equals pc
- i_req  out  1  instruction fetch request
- i_data  in  32  instruction word; valid when i_ready=1
- i_ready  in  1  fetch complete this cycle
- d_addr  out  32  data address (A + zext imm16)
- d_data_w  out  32  store data (R[b])
- d_data_r  in  32  load data; valid when d_ready=1
- d_req  out  1  data access request
- d_we  out  1  1 = store, 0 = load; meaningful only while d_req=1
- d_ready  in  1  data access complete this cycle
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  core stopped on an illegal opcode

Behaviour:
- Reset (async, active-high): pc=RESET_VECTOR, state=FETCH, ir=0, halted=0, retire=0, d_req=0. Register file contents are not reset.
- i_req = (state==FETCH) && !reset.
- FETCH: hold i_req=1 and i_addr=pc until i_ready=1. On i_ready, latch ir=i_data and go to EXEC.
- EXEC: decode ir and read A=R[a], B=R[b].
  - op0 ALU-reg: R[d] = A func B.
  - op1 ALU-imm: R[b] = A func zext(imm16).
  - op2 LW / op3 SW: latch d_addr = A + zext(imm16) and d_data_w = B, then go to MEM.
  - op4 branch:
    - func0 = always taken; func1 = taken if A==0; func2 = taken if A!=0.
    - Taken: pc = pc + (sext(imm16)<<2). Not taken: pc += 4.
    - Any other func is illegal.
  - op5 jump-and-link: R[d] = pc+4, pc = R[b]. If d==b, the link write wins the register and the jump uses the old R[b].
  - Non-branch, non-jump ops: pc += 4.
  - Completion from EXEC pulses retire, writes the register, and returns to FETCH.
  - op6..op15: halted=1, go to HALT. pc, registers and retire are unchanged.
- MEM: d_req=1; d_we=1 for SW, 0 for LW. Address and data stay stable until d_ready.
  - On d_ready: LW writes R[b]=d_data_r; pc += 4; retire=1; go to FETCH.
- HALT: terminal state, left only by reset. i_req=0, d_req=0.
- ALU func codes:
  - 0 MOV(right); 1 AND; 2 OR; 3 XOR; 4 ADD; 5 SUB.
  - 6 SLT (signed) and 7 SLTU, both producing 0/1.
  - 8 SHL and 9 SHR (logical), shift amount = right[4:0].
  - 10..15 produce 0 and are not illegal.
- All arithmetic is mod 2^32; pc wraps 0xFFFFFFFC -> 0x00000000 silently.
- Throughput with zero wait states: 2 cycles per ALU/branch/jump instruction, 3 cycles per LW/SW. Each wait cycle adds 1.
- i_ready outside FETCH and d_ready outside MEM are ignored.
- Reset asserted mid-access drops i_req/d_req in the same cycle (asynchronously); nothing is written.
- R0_ZERO=1: a write to R0 is discarded but still retires.

Test Plan:
- Reset with RESET_VECTOR=32'h100 -> i_addr=0x100 and i_req=1 on the first cycle after deassertion; with i_ready tied high, retire pulses every 2nd cycle on ALU code.
- op1 ADD imm: R1=0+0x7FFF, then op0 SUB R2=R0-R1 -> R2=0xFFFF8001; op1 SHL of 1 by 31 -> 0x80000000; SLT(0x80000000,1)=1, SLTU=0.
- SW R3=0xDEADBEEF to A+0x10 with d_ready delayed 3 cycles -> d_req high 4 cycles with stable d_addr/d_data_w/d_we=1; LW back -> R4=0xDEADBEEF; each completes in 3+3 cycles.
- Branch func1 with R[a]=0, imm16=0xFFFF at pc=0x20 -> next fetch 0x1C; func2 same operands -> next fetch 0x24.
- op5 at pc=0x40 with d=15, R[b]=0x200 -> R15=0x44, next i_addr=0x200; repeat with d==b -> jump to old R[b].
- Opcode 0xF -> halted=1, no retire, i_req stays 0 for 20 cycles; reset asserted mid-LW wait -> d_req drops immediately and the destination register is unchanged.
